// File: rtl/frog_hazard_scanner.sv
// frog_hazard_scanner: per-frame collision/hazard scan of a frog against a lane/object table.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   frame_start, restart  scan request pulse, new-game request (restart wins)
//   frog_x, frog_y        frog position, latched when a scan is accepted
//   obj_lane, obj_idx     object read address driven during the scan
//   obj_valid/kind/x/y/len combinational read data for the current address
//   busy, done, overrun   scan status; done and overrun are one-cycle pulses
//   hit_car .. reached_end, ride_lane  result flags, held from one done to the next
//   death, win            outcome pulses aligned with done
//   lives, score, game_over  game state
module frog_hazard_scanner #(
    parameter int N_LANES = 12,
    parameter int OBJ_PER_LANE = 4,
    parameter logic [9:0] FROG_SIZE = 10'd32,
    parameter logic [9:0] BLOCKSIZE = 10'd32,
    parameter logic [9:0] X_MIN = 10'd96,
    parameter logic [9:0] X_MAX = 10'd576,
    parameter logic [9:0] WATER_Y_MIN = 10'd32,
    parameter logic [9:0] WATER_Y_MAX = 10'd224,
    parameter logic [9:0] END_Y = 10'd32,
    parameter int LIVES = 3,
    localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1,
    localparam int IW = (OBJ_PER_LANE > 1) ? $clog2(OBJ_PER_LANE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          restart,
    input  logic [9:0]    frog_x,
    input  logic [9:0]    frog_y,
    output logic [LW-1:0] obj_lane,
    output logic [IW-1:0] obj_idx,
    input  logic          obj_valid,
    input  logic          obj_kind,
    input  logic [9:0]    obj_x,
    input  logic [9:0]    obj_y,
    input  logic [9:0]    obj_len,
    output logic          busy,
    output logic          done,
    output logic          hit_car,
    output logic          on_log,
    output logic [LW-1:0] ride_lane,
    output logic          in_water,
    output logic          off_screen,
    output logic          reached_end,
    output logic          death,
    output logic          win,
    output logic          overrun,
    output logic [1:0]    lives,
    output logic [7:0]    score,
    output logic          game_over
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, EVAL = 2'd2, OVER = 2'd3;
    localparam logic [1:0] LIVES_V = 2'(LIVES);
    logic [1:0]    state_q, state_d;
    logic [LW-1:0] lane_q, lane_d, acc_lane_q, acc_lane_d, ride_q, ride_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [9:0]    fx_q, fx_d, fy_q, fy_d;
    logic          car_acc_q, car_acc_d, log_acc_q, log_acc_d;
    // {hit_car, on_log, in_water, off_screen, reached_end}
    logic [4:0]    flags_q, flags_d;
    // {done, death, win}
    logic [2:0]    pulse_q, pulse_d;
    logic          overrun_q, overrun_d, go_q, go_d;
    logic [1:0]    lives_q, lives_d;
    logic [7:0]    score_q, score_d;
    logic [10:0]   fx_w, fy_w, fxe_w, fye_w, oxe_w, oye_w;
    logic          overlap, last_idx, last_lane, water, off, reach, die;
    // 11-bit sums so object and frog extents never wrap near the 10-bit limit
    assign fx_w  = {1'b0, fx_q};
    assign fy_w  = {1'b0, fy_q};
    assign fxe_w = fx_w + {1'b0, FROG_SIZE};
    assign fye_w = fy_w + {1'b0, FROG_SIZE};
    assign oxe_w = {1'b0, obj_x} + {1'b0, obj_len};
    assign oye_w = {1'b0, obj_y} + {1'b0, BLOCKSIZE};
    assign overlap = obj_valid && fx_w < oxe_w && fxe_w > {1'b0, obj_x} && fy_w < oye_w && fye_w > {1'b0, obj_y};
    assign last_idx  = idx_q == IW'(OBJ_PER_LANE - 1);
    assign last_lane = lane_q == LW'(N_LANES - 1);
    assign water = fy_q >= WATER_Y_MIN && fy_q < WATER_Y_MAX && !log_acc_q;
    assign off   = fxe_w <= {1'b0, X_MIN} || fx_q >= X_MAX;
    assign reach = fy_q < END_Y;
    assign die   = car_acc_q || water || off;
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        idx_d      = idx_q;
        fx_d       = fx_q;
        fy_d       = fy_q;
        car_acc_d  = car_acc_q;
        log_acc_d  = log_acc_q;
        acc_lane_d = acc_lane_q;
        ride_d     = ride_q;
        flags_d    = flags_q;
        pulse_d    = 3'b000;
        overrun_d  = 1'b0;
        lives_d    = lives_q;
        score_d    = score_q;
        go_d       = go_q;
        if (restart) begin
            state_d    = IDLE;
            lane_d     = '0;
            idx_d      = '0;
            car_acc_d  = 1'b0;
            log_acc_d  = 1'b0;
            acc_lane_d = '0;
            ride_d     = '0;
            flags_d    = '0;
            lives_d    = LIVES_V;
            score_d    = 8'd0;
            go_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (frame_start) begin
                    state_d    = SCAN;
                    fx_d       = frog_x;
                    fy_d       = frog_y;
                    lane_d     = '0;
                    idx_d      = '0;
                    car_acc_d  = 1'b0;
                    log_acc_d  = 1'b0;
                    acc_lane_d = '0;
                end
                SCAN: begin
                    overrun_d = frame_start;
                    car_acc_d = car_acc_q || (overlap && !obj_kind);
                    // only the first log hit in scan order sets the ride lane
                    log_acc_d = log_acc_q || (overlap && obj_kind);
                    acc_lane_d = (overlap && obj_kind && !log_acc_q) ? lane_q : acc_lane_q;
                    idx_d   = last_idx ? '0 : idx_q + 1'b1;
                    lane_d  = last_idx ? (last_lane ? '0 : lane_q + 1'b1) : lane_q;
                    state_d = (last_idx && last_lane) ? EVAL : SCAN;
                end
                EVAL: begin
                    overrun_d = frame_start;
                    flags_d   = {car_acc_q, log_acc_q, water, off, reach};
                    ride_d    = acc_lane_q;
                    pulse_d   = {1'b1, die, reach && !die};
                    lives_d   = die ? lives_q - 2'd1 : lives_q;
                    score_d   = (reach && !die) ? score_q + 8'd1 : score_q;
                    go_d      = die && lives_q == 2'd1;
                    state_d   = (die && lives_q == 2'd1) ? OVER : IDLE;
                end
                default: state_d = OVER;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            idx_q      <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
            car_acc_q  <= 1'b0;
            log_acc_q  <= 1'b0;
            acc_lane_q <= '0;
            ride_q     <= '0;
            flags_q    <= '0;
            pulse_q    <= '0;
            overrun_q  <= 1'b0;
            lives_q    <= LIVES_V;
            score_q    <= 8'd0;
            go_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            idx_q      <= idx_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            car_acc_q  <= car_acc_d;
            log_acc_q  <= log_acc_d;
            acc_lane_q <= acc_lane_d;
            ride_q     <= ride_d;
            flags_q    <= flags_d;
            pulse_q    <= pulse_d;
            overrun_q  <= overrun_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            go_q       <= go_d;
        end
    end
    assign obj_lane = lane_q;
    assign obj_idx  = idx_q;
    assign busy = state_q == SCAN || state_q == EVAL || pulse_q[2];
    assign {done, death, win} = pulse_q;
    assign {hit_car, on_log, in_water, off_screen, reached_end} = flags_q;
    assign ride_lane = ride_q;
    assign overrun   = overrun_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign game_over = go_q;
endmodule

// File: tb/tb_frog_hazard_scanner.sv
// tb_frog_hazard_scanner: table vectors, corner sequences and random frames against a behavioural model.
module tb_frog_hazard_scanner;
    localparam int NL = 12, NO = 4, FS = 32, BS = 32;
    logic clk, reset, frame_start, restart;
    logic [9:0] frog_x, frog_y, obj_x, obj_y, obj_len;
    logic [3:0] obj_lane, ride_lane;
    logic [1:0] obj_idx, lives;
    logic obj_valid, obj_kind, busy, done, hit_car, on_log, in_water, off_screen;
    logic reached_end, death, win, overrun, game_over;
    logic [7:0] score;

    frog_hazard_scanner dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .restart(restart),
        .frog_x(frog_x), .frog_y(frog_y), .obj_lane(obj_lane), .obj_idx(obj_idx),
        .obj_valid(obj_valid), .obj_kind(obj_kind), .obj_x(obj_x), .obj_y(obj_y), .obj_len(obj_len),
        .busy(busy), .done(done), .hit_car(hit_car), .on_log(on_log), .ride_lane(ride_lane),
        .in_water(in_water), .off_screen(off_screen), .reached_end(reached_end),
        .death(death), .win(win), .overrun(overrun), .lives(lives), .score(score), .game_over(game_over)
    );

    bit ov [NL][NO];
    bit okd [NL][NO];
    int oxa [NL][NO];
    int oya [NL][NO];
    int ola [NL][NO];

    always_comb begin
        obj_valid = 1'b0;
        obj_kind  = 1'b0;
        obj_x     = '0;
        obj_y     = '0;
        obj_len   = '0;
        if (int'(obj_lane) < NL) begin
            obj_valid = ov[int'(obj_lane)][int'(obj_idx)];
            obj_kind  = okd[int'(obj_lane)][int'(obj_idx)];
            obj_x     = 10'(oxa[int'(obj_lane)][int'(obj_idx)]);
            obj_y     = 10'(oya[int'(obj_lane)][int'(obj_idx)]);
            obj_len   = 10'(ola[int'(obj_lane)][int'(obj_idx)]);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int m_lives = 3, m_score = 0, m_go = 0;
    int e_hit, e_log, e_rl, e_w, e_off, e_end, e_d, e_win;

    typedef struct {
        int fx, fy, ov, lane, idx, kind, ox, oy, len;
        int hit, lg, rl, w, off, e, d, wn;
    } vec_t;
    vec_t tbl [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clear_objs;
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < NO; i++) begin
                ov[l][i] = 0; okd[l][i] = 0; oxa[l][i] = 0; oya[l][i] = 0; ola[l][i] = 0;
            end
    endtask

    task automatic put_obj(input int l, input int i, input int k, input int x, input int y, input int len);
        ov[l][i] = 1; okd[l][i] = k[0]; oxa[l][i] = x; oya[l][i] = y; ola[l][i] = len;
    endtask

    task automatic model_eval(input int fx, input int fy);
        e_hit = 0; e_log = 0; e_rl = 0;
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < NO; i++)
                if (ov[l][i] && fx < oxa[l][i] + ola[l][i] && fx + FS > oxa[l][i]
                    && fy < oya[l][i] + BS && fy + FS > oya[l][i]) begin
                    if (okd[l][i]) begin
                        if (e_log == 0) e_rl = l;
                        e_log = 1;
                    end else e_hit = 1;
                end
        e_w   = (fy >= 32 && fy < 224 && e_log == 0) ? 1 : 0;
        e_off = (fx + FS <= 96 || fx >= 576) ? 1 : 0;
        e_end = (fy < 32) ? 1 : 0;
        e_d   = (e_hit || e_w || e_off) ? 1 : 0;
        e_win = (e_end && !e_d) ? 1 : 0;
    endtask

    task automatic do_restart;
        restart = 1'b1;
        tick;
        restart = 1'b0;
        m_lives = 3; m_score = 0; m_go = 0;
    endtask

    task automatic run_frame(input int fx, input int fy);
        int dc, gaps;
        model_eval(fx, fy);
        frog_x = 10'(fx);
        frog_y = 10'(fy);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        dc = -1;
        gaps = 0;
        for (int c = 1; c <= 120 && dc < 0; c++) begin
            if (!busy) gaps++;
            if (done) dc = c;
            else tick;
        end
        chk("done_cycle", dc, 50);
        chk("busy_gaps", gaps, 0);
        chk("hit_car", int'(hit_car), e_hit);
        chk("on_log", int'(on_log), e_log);
        chk("ride_lane", int'(ride_lane), e_rl);
        chk("in_water", int'(in_water), e_w);
        chk("off_screen", int'(off_screen), e_off);
        chk("reached_end", int'(reached_end), e_end);
        chk("death", int'(death), e_d);
        chk("win", int'(win), e_win);
        if (e_d) begin
            m_lives--;
            if (m_lives == 0) m_go = 1;
        end
        if (e_win) m_score = (m_score + 1) % 256;
        chk("lives", int'(lives), m_lives);
        chk("score", int'(score), m_score);
        chk("game_over", int'(game_over), m_go);
        tick;
        chk("done_pulse_end", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("hit_car_held", int'(hit_car), e_hit);
    endtask

    initial begin
        int dc, cnt, fx, fy;
        tbl[0]  = '{320, 448, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{320, 256, 1, 8, 0, 0, 300, 256, 64,    1, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{320, 64, 1, 1, 0, 1, 310, 64, 96,      0, 1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{320, 64, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 1, 0, 0, 1, 0};
        tbl[4]  = '{320, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 1, 0, 1};
        tbl[5]  = '{64, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 1, 1, 1, 0};
        tbl[6]  = '{576, 300, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{575, 300, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{320, 256, 1, 0, 0, 0, 352, 256, 64,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{320, 256, 1, 0, 0, 0, 256, 256, 64,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{320, 100, 1, 11, 3, 1, 300, 100, 100,  0, 1, 11, 0, 0, 0, 0, 0};
        tbl[11] = '{320, 224, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{320, 31, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 1, 0, 1};
        tbl[13] = '{320, 32, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 1, 0, 0, 1, 0};
        tbl[14] = '{320, 256, 1, 5, 2, 0, 300, 288, 64,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{320, 256, 1, 5, 2, 0, 300, 225, 64,    1, 0, 0, 0, 0, 0, 1, 0};

        reset = 1'b1; restart = 1'b0; frame_start = 1'b0; frog_x = '0; frog_y = '0;
        clear_objs();
        tick; tick;
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_score", int'(score), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_addr", int'({obj_lane, obj_idx}), 0);
        chk("rst_flags", int'({hit_car, on_log, in_water, off_screen, reached_end, death, win, overrun}), 0);
        chk("rst_ride_lane", int'(ride_lane), 0);
        run_frame(320, 448);

        for (int v = 0; v < 16; v++) begin
            do_restart();
            clear_objs();
            if (tbl[v].ov != 0) put_obj(tbl[v].lane, tbl[v].idx, tbl[v].kind, tbl[v].ox, tbl[v].oy, tbl[v].len);
            run_frame(tbl[v].fx, tbl[v].fy);
            chk($sformatf("tbl%0d_hit", v), int'(hit_car), tbl[v].hit);
            chk($sformatf("tbl%0d_log", v), int'(on_log), tbl[v].lg);
            chk($sformatf("tbl%0d_ride", v), int'(ride_lane), tbl[v].rl);
            chk($sformatf("tbl%0d_water", v), int'(in_water), tbl[v].w);
            chk($sformatf("tbl%0d_off", v), int'(off_screen), tbl[v].off);
            chk($sformatf("tbl%0d_end", v), int'(reached_end), tbl[v].e);
            chk($sformatf("tbl%0d_lives", v), int'(lives), 3 - tbl[v].d);
            chk($sformatf("tbl%0d_score", v), int'(score), tbl[v].wn);
        end

        // two logs: the earlier lane in scan order is the ride lane
        do_restart();
        clear_objs();
        put_obj(7, 1, 1, 300, 100, 80);
        put_obj(3, 2, 1, 310, 100, 80);
        run_frame(320, 100);
        chk("first_log_lane", int'(ride_lane), 3);

        // three deaths end the game; a further frame_start is ignored
        do_restart();
        clear_objs();
        put_obj(8, 0, 0, 300, 256, 64);
        for (int k = 0; k < 3; k++) run_frame(320, 256);
        chk("over_lives", int'(lives), 0);
        chk("over_flag", int'(game_over), 1);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (busy || done || overrun) cnt++;
            tick;
        end
        chk("over_ignores_start", cnt, 0);
        do_restart();
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(score), 0);
        chk("restart_game_over", int'(game_over), 0);
        chk("restart_flags", int'({hit_car, death}), 0);

        // frame_start during the scan: overrun pulse, done timing unchanged
        clear_objs();
        frog_x = 10'd320; frog_y = 10'd448;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 120 && dc < 0; c++) begin
            if (c == 11) chk("overrun_pulse", int'(overrun), 1);
            if (c == 12) chk("overrun_clear", int'(overrun), 0);
            if (done) dc = c;
            else begin
                frame_start = (c == 10);
                tick;
            end
        end
        frame_start = 1'b0;
        chk("overrun_done_cycle", dc, 50);
        tick;

        // restart and frame_start together: restart wins
        restart = 1'b1; frame_start = 1'b1;
        tick;
        restart = 1'b0; frame_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (busy || done) cnt++;
            tick;
        end
        chk("restart_beats_start", cnt, 0);

        // restart mid-scan aborts with no done
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        repeat (15) tick;
        restart = 1'b1;
        tick;
        restart = 1'b0;
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) cnt++;
            tick;
        end
        chk("restart_mid_scan_no_done", cnt, 0);

        // reset at cycle 20 of a scan discards it
        do_restart();
        clear_objs();
        put_obj(0, 0, 0, 300, 256, 64);
        run_frame(320, 256);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        repeat (19) tick;
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        #2;
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_lives", int'(lives), 3);
        tick;
        reset = 1'b0;
        m_lives = 3; m_score = 0; m_go = 0;
        cnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (done || busy) cnt++;
            tick;
        end
        chk("reset_mid_scan_no_done", cnt, 0);

        // random frames against the model
        for (int r = 0; r < 40; r++) begin
            if (m_go != 0) do_restart();
            clear_objs();
            fx = $urandom_range(40, 620);
            fy = ($urandom_range(0, 1) == 1) ? $urandom_range(32, 230) : $urandom_range(0, 480);
            for (int k = $urandom_range(0, 6); k > 0; k--)
                put_obj($urandom_range(0, NL - 1), $urandom_range(0, NO - 1), $urandom_range(0, 1),
                        fx + $urandom_range(0, 200) - 100, (fy >= 40 ? fy - 40 : 0) + $urandom_range(0, 80),
                        $urandom_range(16, 128));
            run_frame(fx, fy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
